// File: rtl/top_multiplier.sv
// top_multiplier: sequential 8x8 signed multiplier using radix-2 Booth recoding.
// One multiplier bit is retired per clock. The 17-bit sign-extended product is
// registered and qualified by Ready.

module top_multiplier (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  M,
  input  logic [7:0]  N,
  output logic [16:0] Product,
  output logic        Ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic        q1_q, q1_d;
  logic [8:0]  mreg_q, mreg_d;
  logic [3:0]  count_q, count_d;
  logic [16:0] product_q, product_d;
  logic        ready_q, ready_d;
  logic [8:0]  sum;

  // Next-state logic: operand load, one Booth add/subtract+shift step, completion and handshake
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    mreg_d    = mreg_q;
    count_d   = count_q;
    product_d = product_q;
    ready_d   = ready_q;
    sum       = a_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (Start) begin
          mreg_d  = {M[7], M};
          q_d     = N;
          a_d     = 9'd0;
          q1_d    = 1'b0;
          count_d = 4'd8;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // The 9-bit accumulator leaves headroom for -(-128) without overflow
        case ({q_q[0], q1_q})
          2'b01:   sum = a_q + mreg_q;
          2'b10:   sum = a_q - mreg_q;
          default: sum = a_q;
        endcase
        a_d     = {sum[8], sum[8:1]};
        q_d     = {sum[0], q_q[7:1]};
        q1_d    = q_q[0];
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          product_d = {a_d[7], a_d[7:0], q_d};
          ready_d   = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        // A held Start keeps the result parked here rather than retriggering
        if (!Start) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any operation in progress
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      a_q       <= 9'd0;
      q_q       <= 8'd0;
      q1_q      <= 1'b0;
      mreg_q    <= 9'd0;
      count_q   <= 4'd0;
      product_q <= 17'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      mreg_q    <= mreg_d;
      count_q   <= count_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  assign Product = product_q;
  assign Ready   = ready_q;

endmodule

// File: tb/tb_top_multiplier.sv
// tb_top_multiplier: directed-vector bench for the Booth multiplier.
// Expected products are hand-computed constants.

module tb_top_multiplier;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  M;
  logic [7:0]  N;
  logic [16:0] Product;
  logic        Ready;

  int          checks;
  int          errors;
  logic [16:0] lastProd;

  top_multiplier dut (
    .clk     (clk),
    .Reset   (Reset),
    .Start   (Start),
    .M       (M),
    .N       (N),
    .Product (Product),
    .Ready   (Ready)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [16:0] actual, input logic [16:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", tag, actual, expected);
    end
  endtask

  // Runs one multiplication: load, wait for Ready within a bounded budget, check latency and product
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] n, input logic [16:0] expProd,
                               input bit scramble, input string tag);
    int edges;
    @(negedge clk);
    M = m;
    N = n;
    Start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_after_load"}, {16'd0, Ready}, 17'd0);
    checkOutput({tag, "_product_held_busy"}, Product, lastProd);
    edges = 0;
    while (Ready !== 1'b1 && edges < 20) begin
      @(negedge clk);
      if (scramble) begin
        M = 8'($urandom);
        N = 8'($urandom);
        Start = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 17'(edges), 17'd8);
    checkOutput({tag, "_product"}, Product, expProd);
    lastProd = expProd;
  endtask

  // Drops Start after a completed operation and expects Ready to fall while Product is held
  task automatic releaseStart(input string tag);
    @(negedge clk);
    Start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_fall"}, {16'd0, Ready}, 17'd0);
    checkOutput({tag, "_product_after_fall"}, Product, lastProd);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    lastProd = 17'd0;
    Reset    = 1'b1;
    Start    = 1'b0;
    M        = 8'd0;
    N        = 8'd0;

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_product", Product, 17'd0);
    checkOutput("reset_ready", {16'd0, Ready}, 17'd0);
    @(negedge clk);
    Reset = 1'b0;

    // 100 * 99, then Start held high in DONE for 50 cycles
    applyStimulus(8'h64, 8'h63, 17'h026AC, 1'b0, "p100x99");
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_ready", {16'd0, Ready}, 17'd1);
      checkOutput("hold_product", Product, 17'h026AC);
    end
    releaseStart("p100x99");

    applyStimulus(8'h9C, 8'h63, 17'h1D954, 1'b0, "m100x99");
    releaseStart("m100x99");
    applyStimulus(8'h80, 8'h80, 17'h04000, 1'b0, "m128xm128");
    releaseStart("m128xm128");
    applyStimulus(8'h80, 8'h7F, 17'h1C080, 1'b0, "m128x127");
    releaseStart("m128x127");
    applyStimulus(8'h7F, 8'h7F, 17'h03F01, 1'b0, "p127x127");
    releaseStart("p127x127");
    applyStimulus(8'h5A, 8'h00, 17'h00000, 1'b0, "x_times_0");
    releaseStart("x_times_0");
    applyStimulus(8'h01, 8'hFF, 17'h1FFFF, 1'b0, "p1xm1");
    releaseStart("p1xm1");
    applyStimulus(8'h00, 8'hFF, 17'h00000, 1'b0, "0xm1");
    releaseStart("0xm1");
    applyStimulus(8'hFF, 8'hFF, 17'h00001, 1'b0, "m1xm1");
    releaseStart("m1xm1");

    // Reset during iteration 4 aborts the operation
    @(negedge clk);
    M = 8'h12;
    N = 8'h34;
    Start = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    Start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_ready", {16'd0, Ready}, 17'd0);
    checkOutput("midreset_product", Product, 17'd0);
    lastProd = 17'd0;
    @(negedge clk);
    Reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midreset_stays_idle", {16'd0, Ready}, 17'd0);
    applyStimulus(8'h03, 8'hFB, 17'h1FFF1, 1'b0, "p3xm5");
    releaseStart("p3xm5");

    // Operands and Start scrambled throughout BUSY; latched -7 * 13 must win
    applyStimulus(8'hF9, 8'h0D, 17'h1FFA5, 1'b1, "scramble");
    releaseStart("scramble");

    // Back-to-back: a new Start is accepted on the cycle after returning to IDLE
    applyStimulus(8'h0B, 8'h0C, 17'h00084, 1'b0, "b2b");
    releaseStart("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
